// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and round-robin helpers for the memory arbiter
package mem_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t XFER    = 2'd1;
  localparam state_t RD_DATA = 2'd2;
  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  // Scan from farthest to nearest so the index closest after last wins.
  function automatic int rr_pick(input logic [7:0] req, input int n, input logic [2:0] last);
    int g;
    g = int'(last);
    for (int k = 8; k >= 1; k--)
      if (k <= n && req[(int'(last) + k) % n]) g = (int'(last) + k) % n;
    return g;
  endfunction
endpackage

// File: rtl/mem_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, last grant has lowest priority
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = owner_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant_idx,
  output logic         any_req
);
  assign grant_idx = W'(rr_pick(8'(req), N, 3'(last_grant)));
  assign any_req   = |req;
endmodule

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: N-client round-robin arbiter in front of one burst memory port
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int NCLIENTS       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2,
  localparam int OW            = owner_w(NCLIENTS)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NCLIENTS*ADDR_WIDTH-1:0]     c_addr,
  input  logic [NCLIENTS*BURSTLEN_WIDTH-1:0] c_burst_len,
  input  logic [NCLIENTS*DATA_WIDTH-1:0]     c_data_in,
  input  logic [NCLIENTS-1:0]                c_wr,
  input  logic [NCLIENTS-1:0]                c_rd,
  output logic [DATA_WIDTH-1:0]              c_data_out,
  output logic [NCLIENTS-1:0]                c_rd_valid,
  output logic [NCLIENTS-1:0]                c_waitrequest,
  output logic [ADDR_WIDTH-1:0]              mm_addr,
  output logic [BURSTLEN_WIDTH-1:0]          mm_burst_len,
  output logic [DATA_WIDTH-1:0]              mm_data_out,
  output logic                               mm_wr,
  output logic                               mm_rd,
  input  logic [DATA_WIDTH-1:0]              mm_data_in,
  input  logic                               mm_waitrequest,
  input  logic                               mm_rd_valid,
  output logic                               busy,
  output logic [OW-1:0]                      owner
);
  state_t                  state;
  logic [OW-1:0]           last_grant;
  logic [OW-1:0]           grant;
  logic                    any_req;
  logic [BURSTLEN_WIDTH:0] cnt;
  logic [BURSTLEN_WIDTH:0] beats;
  logic                    o_rd;
  logic                    o_wr;

  rr_arbiter #(.N(NCLIENTS), .W(OW)) u_pick (
    .req       (c_rd | c_wr),
    .last_grant(last_grant),
    .grant_idx (grant),
    .any_req   (any_req)
  );

  assign o_wr          = c_wr[owner];
  assign o_rd          = c_rd[owner] && !c_wr[owner];
  assign mm_addr       = c_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
  assign mm_burst_len  = c_burst_len[owner*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
  assign mm_data_out   = c_data_in[owner*DATA_WIDTH +: DATA_WIDTH];
  assign mm_rd         = (state == XFER) && o_rd;
  assign mm_wr         = (state == XFER) && o_wr;
  assign c_data_out    = mm_data_in;
  assign c_rd_valid    = (state == RD_DATA) ? ({{(NCLIENTS-1){1'b0}}, mm_rd_valid} << owner) : '0;
  assign c_waitrequest = (state == XFER) ? ~({{(NCLIENTS-1){1'b0}}, !mm_waitrequest} << owner) : '1;
  assign busy          = (state != IDLE);

  // Burst FSM: arbitrate in IDLE, pass one burst through, then rotate priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= OW'(NCLIENTS - 1);
      cnt        <= '0;
      beats      <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= grant;
          cnt   <= '0;
          state <= XFER;
        end
        XFER: if (mm_rd && !mm_waitrequest) begin
          beats <= {1'b0, mm_burst_len} + 1'b1;
          cnt   <= '0;
          state <= RD_DATA;
        end else if (mm_wr && !mm_waitrequest) begin
          if (cnt == {1'b0, mm_burst_len}) begin
            last_grant <= owner;
            cnt        <= '0;
            state      <= IDLE;
          end else cnt <= cnt + 1'b1;
        end else if (!o_rd && !o_wr && cnt == '0) begin
          last_grant <= owner;
          state      <= IDLE;
        end
        RD_DATA: if (mm_rd_valid) begin
          if (cnt + 1'b1 == beats) begin
            last_grant <= owner;
            cnt        <= '0;
            state      <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
